// File: rtl/ucca_config.sv
// ucca_config -- configuration window and lock FSM for the UCC region monitor.
//
// Four-word register window at CONF_BASE (byte address, word aligned):
//   +0 MIN, +2 MAX, +4 CTRL (bit0 = ARM), +6 STATUS
//   STATUS = {violation_count[7:0], 5'b0, arm_err, state[1:0]}
// Once armed, any write into the window is a violation. A violation is
// discarded, pulses `reset` for one cycle and bumps a saturating counter.
//
// Ports:
//   clk, system_reset      clock, synchronous active-high reset
//   pc                     current program counter
//   data_en/wr/addr/din    data bus access
//   ucc_min, ucc_max       registered region bounds
//   ucc_valid              bounds armed (ARMED or LOCKED)
//   per_dout               registered read data (zero unless readback built)
//   reset                  one-cycle violation reset request
//
// Build option: define UCCA_CONF_READBACK_EN to add window readback on per_dout.
module ucca_config #(
  parameter logic [15:0] CONF_BASE = 16'h0160
) (
  input  logic        clk,
  input  logic        system_reset,
  input  logic [15:0] pc,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_din,
  output logic [15:0] ucc_min,
  output logic [15:0] ucc_max,
  output logic        ucc_valid,
  output logic [15:0] per_dout,
  output logic        reset
);

  typedef enum logic [1:0] {
    ST_UNCONFIG = 2'b00,
    ST_ARMED    = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] min_q, max_q, min_nxt, max_nxt;
  logic        arm_err, arm_err_nxt;
  logic [7:0]  viol_cnt;
  logic        reset_q;
  logic        violation;

  // Window decode done in 17 bits so a base near the top of memory cannot wrap.
  logic [16:0] addr_ext, win_lo, win_hi;
  logic        in_win, wr_hit;
  logic [1:0]  reg_sel;
  logic        pc_in_region, arm_ok;

  assign addr_ext = {1'b0, data_addr};
  assign win_lo   = {1'b0, CONF_BASE};
  assign win_hi   = win_lo + 17'd7;
  assign in_win   = (addr_ext >= win_lo) && (addr_ext <= win_hi);
  assign wr_hit   = data_en && data_wr && in_win;
  // CONF_BASE is word aligned, so the word index only needs the 2-bit difference.
  assign reg_sel  = data_addr[2:1] - CONF_BASE[2:1];

  assign pc_in_region = (pc >= min_q) && (pc <= max_q);
  assign arm_ok       = (min_q < max_q) && !min_q[0] && !max_q[0];

  always_comb begin
    state_nxt   = state;
    min_nxt     = min_q;
    max_nxt     = max_q;
    arm_err_nxt = arm_err;
    violation   = 1'b0;
    case (state)
      ST_UNCONFIG: begin
        if (wr_hit) begin
          case (reg_sel)
            2'd0: min_nxt = data_din;
            2'd1: max_nxt = data_din;
            2'd2: begin
              if (data_din[0]) begin
                if (arm_ok) begin
                  state_nxt   = ST_ARMED;
                  arm_err_nxt = 1'b0;
                end else begin
                  arm_err_nxt = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_ARMED: begin
        violation = wr_hit;
        if (pc_in_region) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: violation = wr_hit;
      default:   state_nxt = ST_UNCONFIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state    <= ST_UNCONFIG;
      min_q    <= '0;
      max_q    <= '0;
      arm_err  <= 1'b0;
      viol_cnt <= '0;
      reset_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      min_q   <= min_nxt;
      max_q   <= max_nxt;
      arm_err <= arm_err_nxt;
      reset_q <= violation;
      if (violation && (viol_cnt != 8'hFF)) viol_cnt <= viol_cnt + 8'd1;
    end
  end

  assign ucc_min   = min_q;
  assign ucc_max   = max_q;
  assign ucc_valid = (state == ST_ARMED) || (state == ST_LOCKED);
  assign reset     = reset_q;

`ifdef UCCA_CONF_READBACK_EN
  logic        rd_hit;
  logic [15:0] status;
  logic [15:0] dout_q;

  assign rd_hit = data_en && !data_wr && in_win;
  assign status = {viol_cnt, 5'b0, arm_err, state};

  always_ff @(posedge clk) begin
    if (system_reset) begin
      dout_q <= '0;
    end else if (rd_hit) begin
      case (reg_sel)
        2'd0:    dout_q <= min_q;
        2'd1:    dout_q <= max_q;
        2'd2:    dout_q <= 16'h0000;
        default: dout_q <= status;
      endcase
    end else begin
      dout_q <= '0;
    end
  end

  assign per_dout = dout_q;
`else
  assign per_dout = '0;
`endif

endmodule

// File: tb/tb_ucca_config.sv
module tb_ucca_config;

  localparam logic [15:0] BASE = 16'h0160;

  logic        clk = 1'b0;
  logic        system_reset;
  logic [15:0] pc;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_din;
  logic [15:0] ucc_min;
  logic [15:0] ucc_max;
  logic        ucc_valid;
  logic [15:0] per_dout;
  logic        reset;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ucca_config #(.CONF_BASE(BASE)) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .pc           (pc),
    .data_en      (data_en),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_din     (data_din),
    .ucc_min      (ucc_min),
    .ucc_max      (ucc_max),
    .ucc_valid    (ucc_valid),
    .per_dout     (per_dout),
    .reset        (reset)
  );

  // Reference model: lifecycle flags instead of an encoded state.
  logic [15:0] m_min, m_max, m_dout;
  bit          m_armed, m_locked, m_err, m_pulse;
  int          m_cnt;

  task automatic model_step(input bit rst, input bit en, input bit wr,
                            input logic [15:0] addr, input logic [15:0] din,
                            input logic [15:0] pcv);
    bit          in_win;
    bit          violate;
    int          idx;
    logic [15:0] status;
    if (rst) begin
      m_min = 0; m_max = 0; m_armed = 0; m_locked = 0; m_err = 0;
      m_cnt = 0; m_pulse = 0; m_dout = 0;
      return;
    end
    in_win = en && (int'(addr) >= int'(BASE)) && (int'(addr) <= int'(BASE) + 7);
    idx    = (int'(addr) - int'(BASE)) / 2;
    status = {m_cnt[7:0], 5'b0, m_err, m_locked, m_armed};
    m_dout = 0;
`ifdef UCCA_CONF_READBACK_EN
    if (in_win && !wr) begin
      if (idx == 0) m_dout = m_min;
      else if (idx == 1) m_dout = m_max;
      else if (idx == 3) m_dout = status;
    end
`endif
    violate = in_win && wr && (m_armed || m_locked);
    m_pulse = violate;
    if (violate) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (!m_armed && !m_locked) begin
      if (in_win && wr) begin
        if (idx == 0) m_min = din;
        else if (idx == 1) m_max = din;
        else if (idx == 2 && din[0]) begin
          if (m_min < m_max && (m_min % 2) == 0 && (m_max % 2) == 0) begin
            m_armed = 1; m_err = 0;
          end else begin
            m_err = 1;
          end
        end
      end
    end else if (m_armed && pcv >= m_min && pcv <= m_max) begin
      m_armed = 0; m_locked = 1;
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit wr,
                       input logic [15:0] addr, input logic [15:0] din,
                       input logic [15:0] pcv);
    system_reset = rst; data_en = en; data_wr = wr;
    data_addr = addr; data_din = din; pc = pcv;
    @(posedge clk);
    model_step(rst, en, wr, addr, din, pcv);
    #1;
    system_reset = 0; data_en = 0; data_wr = 0;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic arm_default();
    do_reset();
    drive(0, 1, 1, BASE,     16'hE000, 0);
    drive(0, 1, 1, BASE + 2, 16'hE1FE, 0);
    drive(0, 1, 1, BASE + 4, 16'h0001, 0);
  endtask

  task automatic test_reset();
    drive(0, 1, 1, BASE, 16'h1234, 0);
    do_reset();
    n_checks++; if (ucc_min !== 16'h0000) begin n_fail++; $display("FAIL reset_min: got %h expected 0000", ucc_min); end
    n_checks++; if (ucc_max !== 16'h0000) begin n_fail++; $display("FAIL reset_max: got %h expected 0000", ucc_max); end
    n_checks++; if (ucc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ucc_valid); end
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", reset); end
    n_checks++; if (per_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", per_dout); end
  endtask

  task automatic test_arm_ok();
    logic [15:0] exp_rd;
    arm_default();
    n_checks++; if (ucc_valid !== 1'b1) begin n_fail++; $display("FAIL arm_valid: got %b expected 1", ucc_valid); end
    n_checks++; if (ucc_min !== 16'hE000) begin n_fail++; $display("FAIL arm_min: got %h expected e000", ucc_min); end
    n_checks++; if (ucc_max !== 16'hE1FE) begin n_fail++; $display("FAIL arm_max: got %h expected e1fe", ucc_max); end
    drive(0, 1, 0, BASE + 2, 0, 0);
`ifdef UCCA_CONF_READBACK_EN
    exp_rd = 16'hE1FE;
`else
    exp_rd = 16'h0000;
`endif
    n_checks++; if (per_dout !== exp_rd) begin n_fail++; $display("FAIL read_max: got %h expected %h", per_dout, exp_rd); end
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL read_no_violation: got %b expected 0", reset); end
    drive(0, 1, 0, BASE + 6, 0, 0);
`ifdef UCCA_CONF_READBACK_EN
    exp_rd = 16'h0001;
`endif
    n_checks++; if (per_dout !== exp_rd) begin n_fail++; $display("FAIL read_status_armed: got %h expected %h", per_dout, exp_rd); end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++; if (per_dout !== 16'h0000) begin n_fail++; $display("FAIL read_idle: got %h expected 0000", per_dout); end
  endtask

  task automatic test_arm_fail();
    logic [15:0] exp_rd;
    do_reset();
    drive(0, 1, 1, BASE,     16'hE200, 0);
    drive(0, 1, 1, BASE + 2, 16'hE100, 0);
    drive(0, 1, 1, BASE + 4, 16'h0001, 0);
    n_checks++; if (ucc_valid !== 1'b0) begin n_fail++; $display("FAIL armfail_valid: got %b expected 0", ucc_valid); end
    drive(0, 1, 1, BASE + 6, 16'hFFFF, 0);
    drive(0, 1, 1, BASE + 4, 16'hFFFE, 0);
    drive(0, 1, 0, BASE + 6, 0, 0);
`ifdef UCCA_CONF_READBACK_EN
    exp_rd = 16'h0004;
`else
    exp_rd = 16'h0000;
`endif
    n_checks++; if (per_dout !== exp_rd) begin n_fail++; $display("FAIL armfail_status: got %h expected %h", per_dout, exp_rd); end
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL armfail_pulse: got %b expected 0", reset); end
    // Odd bound must also be refused.
    drive(0, 1, 1, BASE,     16'hE001, 0);
    drive(0, 1, 1, BASE + 2, 16'hE1FE, 0);
    drive(0, 1, 1, BASE + 4, 16'h0001, 0);
    n_checks++; if (ucc_valid !== 1'b0) begin n_fail++; $display("FAIL armfail_odd_valid: got %b expected 0", ucc_valid); end
    n_checks++; if (ucc_min !== 16'hE001) begin n_fail++; $display("FAIL armfail_min_written: got %h expected e001", ucc_min); end
    // Fixing the bound and re-arming succeeds and clears the error.
    drive(0, 1, 1, BASE + 1, 16'hE000, 0);
    drive(0, 1, 1, BASE + 5, 16'h0001, 0);
    n_checks++; if (ucc_valid !== 1'b1) begin n_fail++; $display("FAIL rearm_valid: got %b expected 1", ucc_valid); end
    n_checks++; if (ucc_min !== 16'hE000) begin n_fail++; $display("FAIL rearm_min_oddaddr: got %h expected e000", ucc_min); end
  endtask

  task automatic test_lock_violation();
    logic [15:0] exp_rd;
    arm_default();
    drive(0, 0, 0, 0, 0, 16'hE000);
    drive(0, 0, 0, 0, 0, 16'h0000);
    drive(0, 1, 1, BASE, 16'h0000, 0);
    n_checks++; if (reset !== 1'b1) begin n_fail++; $display("FAIL lock_viol_pulse: got %b expected 1", reset); end
    n_checks++; if (ucc_min !== 16'hE000) begin n_fail++; $display("FAIL lock_viol_min: got %h expected e000", ucc_min); end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL lock_viol_pulse_end: got %b expected 0", reset); end
    drive(0, 1, 0, BASE + 6, 0, 0);
`ifdef UCCA_CONF_READBACK_EN
    exp_rd = 16'h0102;
`else
    exp_rd = 16'h0000;
`endif
    n_checks++; if (per_dout !== exp_rd) begin n_fail++; $display("FAIL lock_status: got %h expected %h", per_dout, exp_rd); end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    logic [15:0] exp_rd;
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, BASE + 16'((i % 4) * 2), 16'(i), 0);
      if (reset === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 300) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 300", pulses); end
    drive(0, 1, 0, BASE + 6, 0, 0);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL sat_pulse_end: got %b expected 0", reset); end
`ifdef UCCA_CONF_READBACK_EN
    exp_rd = 16'hFF02;
`else
    exp_rd = 16'h0000;
`endif
    n_checks++; if (per_dout !== exp_rd) begin n_fail++; $display("FAIL sat_status: got %h expected %h", per_dout, exp_rd); end
  endtask

  task automatic test_same_cycle();
    arm_default();
    drive(0, 1, 1, BASE + 2, 16'h1234, 16'hE100);
    n_checks++; if (reset !== 1'b1) begin n_fail++; $display("FAIL same_pulse: got %b expected 1", reset); end
    n_checks++; if (ucc_max !== 16'hE1FE) begin n_fail++; $display("FAIL same_max: got %h expected e1fe", ucc_max); end
    // Reset mid-pulse, together with another violating write.
    drive(1, 1, 1, BASE, 16'h5555, 16'hE100);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL midpulse_reset: got %b expected 0", reset); end
    n_checks++; if (ucc_valid !== 1'b0) begin n_fail++; $display("FAIL midpulse_valid: got %b expected 0", ucc_valid); end
    n_checks++; if (ucc_min !== 16'h0000 || ucc_max !== 16'h0000) begin n_fail++; $display("FAIL midpulse_bounds: got %h/%h expected 0000/0000", ucc_min, ucc_max); end
    n_checks++; if (per_dout !== 16'h0000) begin n_fail++; $display("FAIL midpulse_dout: got %h expected 0000", per_dout); end
  endtask

  task automatic test_outside();
    do_reset();
    drive(0, 1, 1, BASE - 2, 16'hE000, 0);
    drive(0, 1, 1, BASE + 8, 16'hE1FE, 0);
    n_checks++; if (ucc_min !== 16'h0000 || ucc_max !== 16'h0000) begin n_fail++; $display("FAIL outside_bounds: got %h/%h expected 0000/0000", ucc_min, ucc_max); end
    arm_default();
    drive(0, 1, 1, BASE + 8, 16'h0000, 0);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL outside_no_violation: got %b expected 0", reset); end
    drive(0, 1, 1, BASE - 1, 16'h0000, 0);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL below_no_violation: got %b expected 0", reset); end
  endtask

  task automatic test_random();
    bit          rst, en, wr;
    logic [15:0] addr, din, pcv;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom % 120) == 0;
      en   = ($urandom % 4) != 0;
      wr   = ($urandom % 3) != 0;
      addr = (($urandom % 10) < 7) ? BASE + 16'($urandom % 8) : 16'($urandom);
      din  = 16'($urandom);
      if ($urandom % 2) din[0] = 1'b0;
      if (($urandom % 2) && ((addr - BASE) < 16'd4)) din[15:12] = 4'hE;
      pcv  = {4'hE, 12'($urandom)};
      drive(rst, en, wr, addr, din, pcv);
      n_checks++; if (ucc_min !== m_min) begin n_fail++; $display("FAIL rand_min[%0d]: got %h expected %h", i, ucc_min, m_min); end
      n_checks++; if (ucc_max !== m_max) begin n_fail++; $display("FAIL rand_max[%0d]: got %h expected %h", i, ucc_max, m_max); end
      n_checks++; if (ucc_valid !== (m_armed || m_locked)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, ucc_valid, m_armed || m_locked); end
      n_checks++; if (reset !== m_pulse) begin n_fail++; $display("FAIL rand_pulse[%0d]: got %b expected %b", i, reset, m_pulse); end
      n_checks++; if (per_dout !== m_dout) begin n_fail++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, per_dout, m_dout); end
    end
  endtask

  initial begin
    system_reset = 0; pc = 0; data_en = 0; data_wr = 0; data_addr = 0; data_din = 0;
    test_reset();
    test_arm_ok();
    test_arm_fail();
    test_lock_violation();
    test_saturation();
    test_same_cycle();
    test_outside();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ucca_config.md
UCCA_CONFIG -- requirements
Module: ucca_config

Interface
REQ-001 The module SHALL have parameter CONF_BASE, default 16'h0160, meaning the byte address of the first register in the 4-word configuration window.
REQ-002 The module SHALL have input port clk, 1 bit: the single system clock.
REQ-003 The module SHALL have input port system_reset, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have input port pc, 16 bits: the current program counter.
REQ-005 The module SHALL have input port data_en, 1 bit: data bus access strobe.
REQ-006 The module SHALL have input port data_wr, 1 bit: high for a write, low for a read.
REQ-007 The module SHALL have input port data_addr, 16 bits: data bus byte address.
REQ-008 The module SHALL have input port data_din, 16 bits: write data.
REQ-009 The module SHALL have output port ucc_min, 16 bits: the registered UCC region lower bound.
REQ-010 The module SHALL have output port ucc_max, 16 bits: the registered UCC region upper bound.
REQ-011 The module SHALL have output port ucc_valid, 1 bit: high when the bounds are armed and usable by the region monitor.
REQ-012 The module SHALL have output port per_dout, 16 bits: registered read data.
REQ-013 The module SHALL have output port reset, 1 bit: one-cycle violation reset request.

Function
REQ-014 The register map SHALL be MIN at CONF_BASE+0, MAX at +2, CTRL at +4 (bit0 = ARM), and STATUS at +6.
REQ-015 STATUS SHALL contain bits[1:0] = FSM state, bit2 = ARM_ERR, and bits[15:8] = violation count.
REQ-016 A write SHALL be an access with data_en=1, data_wr=1, and data_addr in [CONF_BASE, CONF_BASE+7], where data_addr[0] is ignored.
REQ-017 The FSM SHALL have three states: UNCONFIG (2'b00), ARMED (2'b01), and LOCKED (2'b10); the encoding 2'b11 SHALL go to UNCONFIG on the next cycle.
REQ-018 In UNCONFIG, a write to MIN or MAX SHALL update that register on the next clk edge.
REQ-019 In UNCONFIG, a write to CTRL with ARM=1 SHALL move the FSM to ARMED only if ucc_min < ucc_max (unsigned) and bit0 of both registers is 0; ARM_ERR SHALL be cleared when it does.
REQ-020 If an ARM write fails the REQ-019 check, the FSM SHALL stay in UNCONFIG and ARM_ERR SHALL be set to 1.
REQ-021 The ARM check SHALL use the register values held before the CTRL write, not any same-cycle update.
REQ-022 ARMED SHALL move to LOCKED on the cycle after ucc_min <= pc <= ucc_max.
REQ-023 LOCKED SHALL be left only by system_reset.
REQ-024 In ARMED or LOCKED, any write to the window SHALL be discarded and SHALL be a violation.
REQ-025 A violation SHALL assert reset for exactly one cycle, on the cycle after the offending write.
REQ-026 Back-to-back violating writes SHALL produce one pulse per write.
REQ-027 Each violation SHALL increment the violation count, which SHALL saturate at 8'hFF.
REQ-028 If a violating write and PC entry into the region occur in the same ARMED cycle, both SHALL take effect: the FSM moves to LOCKED and reset pulses.
REQ-029 ucc_valid SHALL be 1 exactly when the state is ARMED or LOCKED.
REQ-030 Writes to STATUS in UNCONFIG SHALL be ignored.
REQ-031 Writes to CTRL with ARM=0 in UNCONFIG SHALL have no effect.
REQ-032 Accesses outside the window SHALL never affect the module.

Reset
REQ-033 On system_reset=1 at a clk edge, the module SHALL set ucc_min = 16'h0000, ucc_max = 16'h0000, state = UNCONFIG, ARM_ERR = 0, count = 0, reset = 0, per_dout = 16'h0000, and ucc_valid = 0.
REQ-034 system_reset SHALL take priority over any same-cycle write, violation, or PC entry.
REQ-035 A system_reset asserted mid-pulse SHALL deassert reset on the next cycle.

Configuration
REQ-036 With UCCA_CONF_READBACK_EN defined, a read of the window (data_en=1, data_wr=0, address in window) SHALL place the addressed register on per_dout with one-cycle latency.
REQ-037 With UCCA_CONF_READBACK_EN defined, per_dout SHALL be 16'h0000 in all other cycles.
REQ-038 Reads SHALL never cause a violation.
REQ-039 Without UCCA_CONF_READBACK_EN, per_dout SHALL be constant 16'h0000 and no readback logic SHALL be synthesized.

Verification
REQ-040 Write MIN=16'hE000, MAX=16'hE1FE, then CTRL=1 -> ucc_valid=1 the cycle after the CTRL write, and STATUS[1:0]=01.
REQ-041 Write MIN=16'hE200, MAX=16'hE100, then CTRL=1 -> state stays 00, ARM_ERR=1, and ucc_valid=0.
REQ-042 Armed as in REQ-040, drive pc=16'hE000 -> state=10 next cycle; then write MIN=0 -> reset is high for 1 cycle, ucc_min stays 16'hE000, and count=1.
REQ-043 With the module LOCKED, issue 300 violating writes -> 300 reset pulses and count=8'hFF.
REQ-044 In ARMED, write MAX while pc=16'hE100 in the same cycle -> state=10, reset pulses, and MAX is unchanged; then assert system_reset -> all outputs return to their reset values next cycle.
REQ-045 With UCCA_CONF_READBACK_EN defined, read CONF_BASE+2 after REQ-040 -> per_dout=16'hE1FE one cycle later; with the macro undefined, per_dout=0.
